// File: rtl/cache_pkg.sv
// cache_pkg: shared types and widths for the cache lookup-port arbiter.
package cache_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
    localparam int CACHE_ADDR_W = 32;
    localparam int CACHE_DATA_W = 64;
endpackage

// File: rtl/cache_rr_pick.sv
// cache_rr_pick: combinational round-robin pick; search starts at ptr_i and wraps.
module cache_rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    int j;
    // Scan from farthest to nearest so the requester closest to the pointer wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr_i) + i) % N;
            if (req_i[IW'(j)]) begin
                idx_o = IW'(j);
                any_o = 1'b1;
            end
        end
    end
    assign gnt_o = any_o ? (N'(1) << idx_o) : '0;
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of the cache lookup port with one replay on miss.
// Optional watchdog in WAIT enabled by CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = CACHE_ADDR_W,
    parameter int DATA_W         = CACHE_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic                           resp_hit_o,
    output logic [DATA_W-1:0]              resp_data_o,
    output logic                           resp_err_o,
    output logic                           search_cache_o,
    output logic [ADDR_W-1:0]              cache_address_o,
    input  logic                           hit_i,
    input  logic                           search_done_i,
    input  logic [DATA_W-1:0]              data_i,
    output logic                           busy_o,
    output logic                           timeout_flag_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef CACHE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    arb_state_t          state_q;
    logic [IW-1:0]       ptr_q, gnt_q, ptr_d, pick_idx;
    logic [NUM_REQ-1:0]  pick_gnt, rv_q;
    logic                pick_any, replay_q, first_hit_q, search_q, rh_q, err_q, to_flag_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   rd_q;
    logic [WW-1:0]       wd_q;

    cache_rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign ptr_d       = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign req_ready_o = (state_q == ARB_IDLE) ? pick_gnt : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            replay_q    <= 1'b0;
            first_hit_q <= 1'b0;
            search_q    <= 1'b0;
            rv_q        <= '0;
            rh_q        <= 1'b0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            to_flag_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            rv_q     <= '0;
            rh_q     <= 1'b0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            search_q <= 1'b0;
            case (state_q)
                ARB_IDLE: if (pick_any) begin
                    gnt_q    <= pick_idx;
                    addr_q   <= req_addr_i[pick_idx];
                    search_q <= 1'b1;
                    ptr_q    <= ptr_d;
                    state_q  <= ARB_ISSUE;
                end
                ARB_ISSUE: begin
                    wd_q    <= '0;
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: if (search_done_i) begin
                    if (replay_q || hit_i) begin
                        rv_q     <= NUM_REQ'(1) << gnt_q;
                        rh_q     <= replay_q ? first_hit_q : 1'b1;
                        rd_q     <= data_i;
                        replay_q <= 1'b0;
                        state_q  <= ARB_IDLE;
                    end else begin
                        first_hit_q <= hit_i;
                        replay_q    <= 1'b1;
                        search_q    <= 1'b1;
                        state_q     <= ARB_ISSUE;
                    end
                end else if (TO_EN && wd_q == WW'(TIMEOUT_CYCLES)) begin
                    rv_q      <= NUM_REQ'(1) << gnt_q;
                    err_q     <= 1'b1;
                    to_flag_q <= 1'b1;
                    replay_q  <= 1'b0;
                    state_q   <= ARB_IDLE;
                end else begin
                    wd_q <= TO_EN ? wd_q + 1'b1 : '0;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign resp_valid_o    = rv_q;
    assign resp_hit_o      = rh_q;
    assign resp_data_o     = rd_q;
    assign resp_err_o      = err_q;
    assign search_cache_o  = search_q;
    assign cache_address_o = addr_q;
    assign busy_o          = state_q != ARB_IDLE;
    assign timeout_flag_o  = to_flag_q;
endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Round-robin arbiter and sequencer that shares the single lookup port of the set-associative cache between NUM_REQ requesters, e.g. instruction fetch and load/store. It accepts requests with a valid/ready handshake and holds the cache address stable for the whole lookup. It drives the one-cycle `search_cache` start pulse, waits for `search_done`, and replays a missed lookup once so the requester always receives refilled data. It sits between the requesters and the cache's `search_cache`/`address`/`hit`/`search_done`/`data` port.

## Interface
- NUM_REQ, 2: number of requesters (2..8)
- ADDR_W, 32: address width
- DATA_W, 64: data word width
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT (used only with timeout compiled in)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_addr  in  NUM_REQ x ADDR_W  per-requester byte address
- req_ready  out  NUM_REQ  one-hot accept, combinational
- resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
- resp_hit  out  1  first lookup hit
- resp_data  out  DATA_W  returned word
- resp_err  out  1  lookup timed out
- search_cache  out  1  one-cycle lookup start to cache
- cache_address  out  ADDR_W  held stable from ISSUE through the end of WAIT
- hit  in  1  cache hit flag
- search_done  in  1  cache completion flag
- data  in  DATA_W  cache data
- busy  out  1  state != IDLE
- timeout_flag  out  1  sticky; set on any timeout

## Operation
- Reset value of every output is 0: search_cache, cache_address, resp_*, busy, timeout_flag. req_ready is 0 because state is IDLE with no valid requests. State goes to IDLE, rr pointer to 0, replay flag to 0.
- States:
  - IDLE: req_ready is high only for the winner. Round-robin search starts at the pointer and wraps from NUM_REQ-1 to 0. On accept, latch grant index and address, register search_cache=1, go to ISSUE, and set pointer = grant+1 mod NUM_REQ.
  - ISSUE: search_cache=0 next; go to WAIT; clear watchdog.
  - WAIT, search_done=1 on first lookup:
    - if hit=1: register resp_valid[grant]=1, resp_hit=1, resp_data=data; go to IDLE.
    - if hit=0: save first_hit=0, set replay, search_cache=1; go to ISSUE.
  - WAIT, search_done=1 on replay lookup: register resp_valid[grant]=1, resp_hit=first_hit (0), resp_data=data; clear replay; go to IDLE. Exactly one replay is performed, whatever the replay's hit value.
- No requests while busy: req_ready is all-zero outside IDLE.
- Simultaneous requests: only the round-robin winner gets ready. Others hold req_valid and are served in rotation order.
- A requester drops req_valid only after req_ready; req_addr need not persist after acceptance.
- resp_valid, resp_hit, resp_data and resp_err are valid for exactly one cycle. resp_hit, resp_data and resp_err are 0 when resp_valid=0.
- Reset mid-operation drops the in-flight request without any response; requesters reissue.
- search_done observed in IDLE or ISSUE is ignored. It is a stale trailing cycle.

## Timing
- Acceptance at edge A, then search_cache is high for the cycle A..A+1.
- Hit: resp_valid is high in the cycle after edge A+3.
- Miss: cache refill done at A+7, replay issued at A+8, resp_valid high after edge A+11.
- Next acceptance can occur at the edge after resp_valid is registered. With continuous requests, the back-to-back hit throughput is one per 4 cycles.

## Configuration
- CACHE_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT.
  - When it reaches TIMEOUT_CYCLES without search_done: resp_valid[grant]=1, resp_err=1, resp_hit=0, resp_data=0. timeout_flag is set (cleared only by reset), replay is cleared, and the state goes to IDLE.
- Not defined: no counter, resp_err and timeout_flag are tied 0, and WAIT waits indefinitely.

## Structure
- Package cache_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - CACHE_ADDR_W=32, CACHE_DATA_W=64 constants
- Sub-module cache_rr_pick: combinational round-robin pick.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.

## Test plan
- Single request, requester 0, address 0x0000_0040, cache model hits with data 0xDEAD_BEEF_0000_0001 -> req_ready[0] at A; resp_valid[0], resp_hit=1 and that data after A+3.
- Same address, cache model misses then hits on replay with 0x1234 -> exactly two search_cache pulses; resp_hit=0, data 0x1234 after A+11.
- req_valid=2'b11 held for 4 transactions, all hits -> grant order 0,1,0,1; each resp_valid one-hot; cache_address matches the granted req_addr throughout.
- Timeout compiled in, TIMEOUT_CYCLES=8, search_done never asserted -> resp_err=1, resp_data=0, timeout_flag stays 1; the next request is served normally.
- reset pulsed during WAIT -> all outputs 0 immediately; no resp_valid; pointer 0; a subsequent request to requester 1 is served with hit latency 3.
